// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for a single 32-bit, 1-cycle-latency BRAM port.
// The lock option keeps a burst on one engine, but only for a bounded number of grants while the other engine waits.
module bram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wrdata,
  input  logic [DATA_W-1:0] m1_wrdata,
  input  logic [3:0]        m0_we,
  input  logic [3:0]        m1_we,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rdvalid,
  output logic              m1_rdvalid,
  output logic [DATA_W-1:0] m0_rddata,
  output logic [DATA_W-1:0] m1_rddata,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic [DATA_W-1:0] BRAM_wrdata,
  output logic [3:0]        BRAM_we,
  input  logic [DATA_W-1:0] BRAM_rddata,
  output logic [31:0]       arb_status
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              own_lock_q, own_lock_d;
  logic [7:0]        hold_q, hold_d;
  logic              bad_we_q, bad_we_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        rdvalid_q, rdvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       status_q, status_d;

  logic              grant_any;
  logic              gsel;
  logic              req_both;
  logic              lock_last;
  logic              timeout_hit;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wrdata;
  logic [3:0]        g_we;
  logic              g_lock;

  always_comb begin
    grant_any   = 1'b0;
    gsel        = 1'b0;
    timeout_hit = 1'b0;
    req_both    = m0_req & m1_req;
    lock_last   = last_q ? m1_lock : m0_lock;
    // Grants are masked while reset is held so the port is quiet immediately.
    if (reset) begin
      if (req_both) begin
        grant_any = 1'b1;
        if (valid_q && lock_last && (hold_q < MAX_HOLD_C)) begin
          gsel = last_q;
        end else begin
          gsel        = ~last_q;
          timeout_hit = valid_q & lock_last;
        end
      end else if (m0_req || m1_req) begin
        grant_any = 1'b1;
        gsel      = m1_req;
      end
    end

    g_addr   = gsel ? m1_addr   : m0_addr;
    g_wrdata = gsel ? m1_wrdata : m0_wrdata;
    g_we     = gsel ? m1_we     : m0_we;
    g_lock   = gsel ? m1_lock   : m0_lock;

    m0_gnt      = grant_any & ~gsel;
    m1_gnt      = grant_any & gsel;
    BRAM_addr   = grant_any ? g_addr : addr_q;
    BRAM_wrdata = grant_any ? g_wrdata : '0;
    BRAM_we     = grant_any ? g_we : 4'h0;

    last_d     = grant_any ? gsel : last_q;
    valid_d    = grant_any;
    own_lock_d = grant_any & g_lock;
    addr_d     = grant_any ? g_addr : addr_q;

    // The hold count only grows while the same engine keeps winning a contested port.
    if (grant_any && req_both && valid_q && (gsel == last_q)) begin
      hold_d = (hold_q >= MAX_HOLD_C) ? MAX_HOLD_C : hold_q + 8'd1;
    end else begin
      hold_d = 8'd0;
    end

    bad_we_d  = bad_we_q | (grant_any & (g_we != 4'h0) & (g_we != 4'hf));
    timeout_d = timeout_q | timeout_hit;
    rdvalid_d = {m1_gnt & (m1_we == 4'h0), m0_gnt & (m0_we == 4'h0)};

    status_d = {16'h0000, hold_d, 3'b000, timeout_d, bad_we_d, own_lock_d,
                valid_d & last_d, valid_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      valid_q    <= 1'b0;
      own_lock_q <= 1'b0;
      hold_q     <= 8'd0;
      bad_we_q   <= 1'b0;
      timeout_q  <= 1'b0;
      rdvalid_q  <= 2'b00;
      addr_q     <= '0;
      status_q   <= 32'h0;
    end else begin
      last_q     <= last_d;
      valid_q    <= valid_d;
      own_lock_q <= own_lock_d;
      hold_q     <= hold_d;
      bad_we_q   <= bad_we_d;
      timeout_q  <= timeout_d;
      rdvalid_q  <= rdvalid_d;
      addr_q     <= addr_d;
      status_q   <= status_d;
    end
  end

  assign m0_rdvalid = rdvalid_q[0];
  assign m1_rdvalid = rdvalid_q[1];
  assign m0_rddata  = BRAM_rddata;
  assign m1_rddata  = BRAM_rddata;
  assign arb_status = status_q;

  logic unused_own_lock;
  assign unused_own_lock = own_lock_q;

endmodule
